// File: rtl/pipe_hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_pkg
// Description : Shared types and constants for the pipeline hazard controller:
//               controller state encoding and Execute-stage forwarding selects.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_hazard_pkg;

    // Controller sequencing state
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERR     = 2'd2
    } state_t;

    // Execute operand mux3 selects
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
`default_nettype none
// ============================================================================
// Module      : fwd_unit
// Description : Forwarding select for one Execute-stage source operand.
//               The Memory stage result is younger, so it wins over Writeback.
//               Register x0 is never forwarded.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_unit
    import pipe_hazard_pkg::*;
(
    input  logic [4:0] rsE,
    input  logic [4:0] rdM,
    input  logic [4:0] rdW,
    input  logic       regwriteM,
    input  logic       regwriteW,
    output logic [1:0] fwd
);

    // Priority select: Memory result, then Writeback result, then regfile
    always_comb begin
        fwd = FWD_RF;
        if ((rsE != 5'd0) && regwriteM && (rdM == rsE)) begin
            fwd = FWD_MEM;
        end else if ((rsE != 5'd0) && regwriteW && (rdW == rsE)) begin
            fwd = FWD_WB;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Hazard and sequencing controller for the 5-stage pipeline.
//               Produces operand forwarding selects, stall/flush enables for
//               the pipeline registers, freezes the pipe on a slow data
//               memory (trapping to a sticky error on timeout) and maintains
//               wrap-around performance counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
)(
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1D,
    input  logic [4:0]       rs2D,
    input  logic [4:0]       rs1E,
    input  logic [4:0]       rs2E,
    input  logic [4:0]       rdE,
    input  logic [4:0]       rdM,
    input  logic [4:0]       rdW,
    input  logic             regwriteM,
    input  logic             regwriteW,
    input  logic             loadE,
    input  logic             pcsrcE,
    input  logic             memreqM,
    input  logic             dmem_ready,
    input  logic             validW,
    output logic [1:0]       forwardAE,
    output logic [1:0]       forwardBE,
    output logic             stallF,
    output logic             stallD,
    output logic             stallE,
    output logic             stallM,
    output logic             flushD,
    output logic             flushE,
    output logic             flushW,
    output logic             mem_err,
    output logic [CNT_W-1:0] cyc_cnt,
    output logic [CNT_W-1:0] ret_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    // TIMEOUT is capped at 255, so an 8-bit wait counter always suffices
    localparam int         c_WAIT_W    = 8;
    localparam logic [7:0] c_WAIT_LAST = 8'(TIMEOUT - 1);

    state_t              r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic                w_lw_stall;
    logic                w_memwait;

    // Operand A and B forwarding
    fwd_unit u_fwd_a (
        .rsE       (rs1E),
        .rdM       (rdM),
        .rdW       (rdW),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .fwd       (forwardAE)
    );

    fwd_unit u_fwd_b (
        .rsE       (rs2E),
        .rdM       (rdM),
        .rdW       (rdW),
        .regwriteM (regwriteM),
        .regwriteW (regwriteW),
        .fwd       (forwardBE)
    );

    // Load-use hazard: Decode reads a register still being loaded in Execute
    assign w_lw_stall = loadE && (rdE != 5'd0) && ((rs1D == rdE) || (rs2D == rdE));

    // Memory freeze request; ERR keeps the pipe frozen until reset
    always_comb begin
        w_memwait = 1'b0;
        case (r_state)
            RUN:     w_memwait = memreqM && !dmem_ready;
            MEMWAIT: w_memwait = !dmem_ready;
            ERR:     w_memwait = 1'b1;
            default: w_memwait = 1'b1;
        endcase
    end

    // Stall and flush enables; a memory freeze overrides branch and load-use
    // handling so a branch held in Execute resolves once the wait ends
    always_comb begin
        stallF = w_lw_stall;
        stallD = w_lw_stall;
        stallE = 1'b0;
        stallM = 1'b0;
        flushD = pcsrcE;
        flushE = w_lw_stall || pcsrcE;
        flushW = 1'b0;
        if (w_memwait) begin
            stallF = 1'b1;
            stallD = 1'b1;
            stallE = 1'b1;
            stallM = 1'b1;
            flushD = 1'b0;
            flushE = 1'b0;
            flushW = 1'b1;
        end
    end

    // Sequencing FSM with wait timeout and sticky error flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= RUN;
            r_wait_cnt <= '0;
            mem_err    <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_memwait) begin
                        r_state    <= MEMWAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                MEMWAIT: begin
                    if (dmem_ready) begin
                        r_state    <= RUN;
                        r_wait_cnt <= '0;
                    end else if (r_wait_cnt == c_WAIT_LAST) begin
                        r_state <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ERR: begin
                    r_state <= ERR;
                end
                default: begin
                    r_state <= ERR;
                    mem_err <= 1'b1;
                end
            endcase
        end
    end

    // Wrap-around performance counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_cnt   <= '0;
            ret_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            cyc_cnt   <= cyc_cnt + CNT_W'(1);
            ret_cnt   <= ret_cnt + CNT_W'(validW);
            stall_cnt <= stall_cnt + CNT_W'(stallF);
            flush_cnt <= flush_cnt + CNT_W'(pcsrcE && !w_memwait);
        end
    end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central hazard and sequencing controller for the 5-stage RV32 + RVX10 pipeline. It sits beside the datapath stages.
- Generates forwarding selects for the Execute-stage operand mux3 instances.
- Generates stall and flush enables for the F/D/E/M/W pipeline registers.
- Freezes the pipe while a variable-latency data memory is busy, with a timeout that traps to a sticky error.
- Keeps wrap-around performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.
- TIMEOUT, 16, consecutive memory-wait cycles that force the ERR state (legal range 2..255).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- rs1D, rs2D  in  5 each  source registers in Decode
- rs1E, rs2E, rdE  in  5 each  source and destination registers in Execute
- rdM, rdW  in  5 each  destination registers in Memory and Writeback
- regwriteM, regwriteW  in  1 each  register-write enable in M and W
- loadE  in  1  Execute instruction is a load (resultsrc==01)
- pcsrcE  in  1  taken branch or jump resolved in Execute
- memreqM  in  1  Memory-stage instruction accesses data memory
- dmem_ready  in  1  data memory completes this cycle
- validW  in  1  Writeback holds a real (non-bubble) instruction
- forwardAE, forwardBE  out  2 each  operand select: 00 regfile, 01 ResultW, 10 ALUResultM
- stallF, stallD, stallE, stallM  out  1 each  hold the corresponding register
- flushD, flushE, flushW  out  1 each  load a bubble into the corresponding register
- mem_err  out  1  sticky memory-timeout error
- cyc_cnt, ret_cnt, stall_cnt, flush_cnt  out  CNT_W each  performance counters

Behaviour:
- Reset (async): state=RUN, wait_cnt=0, mem_err=0, all counters=0.
- Reset is honoured mid-wait or in ERR; the controller returns to RUN on the next cycle after deassertion.
- Forwarding (combinational), evaluated for A with rs1E and for B with rs2E:
  - rsE!=0 && regwriteM && rdM==rsE -> 10.
  - else rsE!=0 && regwriteW && rdW==rsE -> 01.
  - else 00.
  - M has priority over W.
- lwStall = loadE && rdE!=0 && (rs1D==rdE || rs2D==rdE).
- memwait (combinational):
  - RUN: memreqM && !dmem_ready.
  - MEMWAIT: !dmem_ready.
  - ERR: 1.
- Output equations when memwait=0:
  - stallF = stallD = lwStall.
  - stallE = stallM = 0.
  - flushD = pcsrcE.
  - flushE = lwStall || pcsrcE.
  - flushW = 0.
- Output equations when memwait=1:
  - stallF = stallD = stallE = stallM = 1.
  - flushD = flushE = 0. A branch held in E resolves after the wait.
  - flushW = 1.
- FSM states: RUN, MEMWAIT, ERR.
- RUN transitions:
  - memwait -> MEMWAIT, wait_cnt <= 1.
  - else stay.
- MEMWAIT transitions:
  - dmem_ready -> RUN, wait_cnt <= 0.
  - else if wait_cnt == TIMEOUT-1 -> ERR, mem_err <= 1.
  - else wait_cnt++.
- ERR: absorbing until reset.
- dmem_ready in the same cycle as memreqM in RUN means zero-wait; no state change.
- Counters increment at posedge and wrap modulo 2^CNT_W:
  - cyc_cnt: +1 every cycle.
  - ret_cnt: +validW.
  - stall_cnt: +stallF.
  - flush_cnt: +(pcsrcE && !memwait).
- All outputs other than the FSM, counters and mem_err are combinational. Every counter update has one-cycle latency.

Decomposition:
- Package pipe_hazard_pkg holds:
  - State enum {RUN, MEMWAIT, ERR}.
  - Forward select constants FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
- Sub-module fwd_unit: combinational forwarding for one operand (rsE, rdM, rdW, regwriteM, regwriteW -> 2-bit select). It is instantiated twice.

Test Plan:
- Forward priority: rs1E=5, rdM=5, regwriteM=1, rdW=5, regwriteW=1 -> forwardAE=10. Drop regwriteM -> 01. Set rs1E=0 -> 00.
- Load-use: loadE=1, rdE=7, rs2D=7 -> stallF=stallD=1, flushE=1, stall_cnt +1 next cycle. rdE=0 -> no stall.
- Branch: pcsrcE=1, memreqM=0 -> flushD=flushE=1, flush_cnt +1. Same with memreqM=1, dmem_ready=0 -> flushD=flushE=0, all stalls=1, flushW=1, flush_cnt unchanged.
- Memory wait: memreqM=1, dmem_ready low 3 cycles then high -> memwait=1 for 3 cycles, state MEMWAIT then RUN, mem_err=0, ret_cnt counts only validW cycles.
- Timeout: TIMEOUT=16, dmem_ready held low -> ERR entered at the 16th edge, mem_err=1 and stays 1 even when dmem_ready rises. Async reset -> mem_err=0, state RUN, counters 0.
- Wrap: CNT_W=4, run 17 cycles -> cyc_cnt=1.
